// File: rtl/div_seq_ctrl_if.sv
// Handshake and data bundle between the EX stage and the multi-cycle divide sequencer.
// The master side (EX stage) issues requests; the slave side (sequencer) reports status and result.
interface div_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;

  modport master (
    output start, func3, dividend, divisor, flush,
    input  busy, done, result, stall
  );

  modport slave (
    input  start, func3, dividend, divisor, flush,
    output busy, done, result, stall
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divider with sign pre/post-correction.
// It stalls EX until the one-cycle done pulse; a flush aborts the operation and leaves result untouched.
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_signed;
  logic             r_sel_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [XLEN-1:0]  r_result;

  logic            w_accept;
  logic            w_div0;
  logic            w_ovf;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic            w_last;
  logic            w_busy;
  logic            w_done;

  assign w_accept = bus.start & bus.func3[2] & ~bus.flush;
  assign w_div0   = (r_b == '0);
  assign w_ovf    = r_signed & (r_a == {1'b1, {(XLEN-1){1'b0}}}) & (r_b == '1);
  assign w_a_neg  = r_signed & r_a[XLEN-1];
  assign w_b_neg  = r_signed & r_b[XLEN-1];
  assign w_a_abs  = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_b_abs  = w_b_neg ? (~r_b + 1'b1) : r_b;

  // Shifted partial remainder can reach 2*divisor, so the trial needs one extra bit;
  // its MSB doubles as the "trial went negative" flag.
  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_trial  = w_shift - {1'b0, r_b};
  assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

  assign w_q_fix  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix  = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_PREP;
      end
      S_PREP: begin
        w_busy = 1'b1;
        w_next = (w_div0 || w_ovf) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.flush && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a       <= bus.dividend;
            r_b       <= bus.divisor;
            r_signed  <= ~bus.func3[0];
            r_sel_rem <= bus.func3[1];
          end
        end
        S_PREP: begin
          if (!bus.flush) begin
            if (w_div0) begin
              r_result <= r_sel_rem ? r_a : '1;
            end else if (w_ovf) begin
              r_result <= r_sel_rem ? '0 : r_a;
            end
          end
          // r_b is reused as the magnitude divisor for the iterations
          r_quo   <= w_a_abs;
          r_b     <= w_b_abs;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
        end
        S_CALC: begin
          r_rem <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (!bus.flush) r_result <= r_sel_rem ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.stall  = bus.start & bus.func3[2] & ~w_done & ~bus.flush;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl: latency, signed/unsigned results,
// divide-by-zero, signed overflow, flush and asynchronous reset aborts.
module tb_div_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  div_seq_ctrl_if #(.XLEN(32)) bus ();

  div_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request in IDLE and waits for done; lat is the cycle index (T+lat) of done, -1 on timeout.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stall_bad);
    lat       = -1;
    stall_bad = 0;
    res       = '0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.func3    = f3;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (bus.stall !== 1'b0) stall_bad++;
        lat = k;
        res = bus.result;
        bus.start = 1'b0;
        break;
      end
      if (bus.stall !== 1'b1) stall_bad++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++;
    if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", bus.result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ignore_func3();
    @(negedge clk);
    bus.start = 1'b1;
    bus.func3 = 3'b000;
    bus.dividend = 32'd10;
    bus.divisor  = 32'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL nodiv_stall got=%b exp=0", bus.stall); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL nodiv_busy got=%b exp=0", bus.busy); end
    bus.start = 1'b0;
  endtask

  task automatic test_div_normal();
    logic [31:0] res;
    int lat, sb;
    run_op(3'b100, 32'd100, 32'd7, res, lat, sb);
    checks++;
    if (res !== 32'd14) begin failures++; $display("FAIL div_100_7 got=%h exp=0000000e", res); end
    checks++;
    if (lat !== 35) begin failures++; $display("FAIL div_latency got=%0d exp=35", lat); end
    checks++;
    if (sb !== 0) begin failures++; $display("FAIL div_stall_window got=%0d bad cycles exp=0", sb); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL div_busy_after got=%b exp=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL div_done_pulse got=%b exp=0", bus.done); end
    checks++;
    if (bus.result !== 32'd14) begin failures++; $display("FAIL div_result_hold got=%h exp=0000000e", bus.result); end
  endtask

  task automatic test_signed();
    logic [31:0] res;
    int lat, sb;
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, res, lat, sb);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", res); end
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, res, lat, sb);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=fffffffd", res); end
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, res, lat, sb);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_7_m2 got=%h exp=fffffffd", res); end
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, res, lat, sb);
    checks++;
    if (res !== 32'd1) begin failures++; $display("FAIL rem_7_m2 got=%h exp=00000001", res); end
  endtask

  task automatic test_unsigned();
    logic [31:0] res;
    int lat, sb;
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, res, lat, sb);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_max_1 got=%h exp=ffffffff", res); end
    run_op(3'b111, 32'hFFFF_FFFF, 32'h10, res, lat, sb);
    checks++;
    if (res !== 32'hF) begin failures++; $display("FAIL remu_max_16 got=%h exp=0000000f", res); end
    checks++;
    if (lat !== 35) begin failures++; $display("FAIL remu_latency got=%0d exp=35", lat); end
    run_op(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sb);
    checks++;
    if (res !== 32'h8000_0000) begin failures++; $display("FAIL remu_min_allones got=%h exp=80000000", res); end
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sb);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL divu_min_allones got=%h exp=00000000", res); end
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    int lat, sb;
    run_op(3'b100, 32'd5, 32'd0, res, lat, sb);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_by0 got=%h exp=ffffffff", res); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL div_by0_latency got=%0d exp=2", lat); end
    run_op(3'b110, 32'd5, 32'd0, res, lat, sb);
    checks++;
    if (res !== 32'd5) begin failures++; $display("FAIL rem_by0 got=%h exp=00000005", res); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL rem_by0_latency got=%0d exp=2", lat); end
    run_op(3'b101, 32'd5, 32'd0, res, lat, sb);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by0 got=%h exp=ffffffff", res); end
  endtask

  task automatic test_overflow();
    logic [31:0] res;
    int lat, sb;
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sb);
    checks++;
    if (res !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", res); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL div_ovf_latency got=%0d exp=2", lat); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sb);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=00000000", res); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, sb, seen;
    run_op(3'b101, 32'd20, 32'd4, res, lat, sb);
    checks++;
    if (res !== 32'd5) begin failures++; $display("FAIL flush_pre got=%h exp=00000005", res); end
    @(negedge clk);
    bus.start    = 1'b1;
    bus.func3    = 3'b100;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    bus.flush = 1'b1;
    bus.start = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.result !== 32'd5) begin failures++; $display("FAIL flush_result got=%h exp=00000005", bus.result); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_no_done got=%0d pulses exp=0", seen); end
    run_op(3'b101, 32'd9, 32'd3, res, lat, sb);
    checks++;
    if (res !== 32'd3) begin failures++; $display("FAIL flush_recover got=%h exp=00000003", res); end
    checks++;
    if (lat !== 35) begin failures++; $display("FAIL flush_recover_latency got=%0d exp=35", lat); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat, sb;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.func3    = 3'b101;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd5;
    @(posedge clk);
    repeat (20) @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", bus.done); end
    checks++;
    if (bus.result !== 32'h0) begin failures++; $display("FAIL arst_result got=%h exp=00000000", bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b101, 32'd9, 32'd3, res, lat, sb);
    checks++;
    if (res !== 32'd3) begin failures++; $display("FAIL arst_recover got=%h exp=00000003", res); end
    checks++;
    if (lat !== 35) begin failures++; $display("FAIL arst_recover_latency got=%0d exp=35", lat); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.func3    = 3'b000;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.flush    = 1'b0;
    test_reset();
    test_ignore_func3();
    test_div_normal();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for RV32M division: DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the EX stage.
- Owns a radix-2 restoring shift-subtract datapath and the sign pre- and post-correction.
- Holds the pipeline through a stall output until the result is ready; receives the func3 field already qualified by the decoder.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level request; EX holds a divide instruction. Sampled only in IDLE.
- func3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU. Bit 2 must be 1; otherwise the request is ignored.
- dividend  input  XLEN  rs1 value, captured at accept.
- divisor  input  XLEN  rs2 value, captured at accept.
- flush  input  1  pipeline flush; aborts any operation in flight.
- busy  output  1  high in PREP, CALC, FIX.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- stall  output  1  combinational: start & func3[2] & ~done & ~flush.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0. Reset takes effect immediately, including mid-operation; no done is produced for an aborted operation.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - If start & func3[2] & ~flush: latch operands, op, and signed flag = ~func3[0]. Go to PREP.
  - Otherwise stay in IDLE.
- PREP (1 cycle): decide the path in this order.
  - Divide by zero (divisor==0): quotient = all ones, remainder = dividend. Go to DONE.
  - Signed overflow (signed op, dividend = 0x80000000, divisor = all ones): quotient = dividend, remainder = 0. Go to DONE.
  - Otherwise: load the absolute values (signed ops) or raw values (unsigned ops); record neg_q = sign(a) ^ sign(b) and neg_r = sign(a); clear the remainder and the counter. Go to CALC.
- CALC: runs exactly XLEN cycles.
  - Each cycle: shift {rem, quo} left by 1; trial = rem_shifted - divisor, at XLEN+1 bits.
  - If trial is non-negative: rem = trial and quotient LSB = 1; otherwise quotient LSB = 0.
  - Counter increments; at count XLEN-1 go to FIX.
- FIX (1 cycle): negate quotient if neg_q, negate remainder if neg_r (two's complement, XLEN bits, wrap). Select the output by func3[1]. Go to DONE.
- DONE (1 cycle): done=1 and result registered. Return to IDLE.
  - A new start may be accepted in the following IDLE cycle; the pipeline has advanced by then.
- Latency from the accept edge T:
  - Normal path: done high in cycle T+35 (1 PREP + 32 CALC + 1 FIX + 1 to DONE).
  - Special cases: done high in cycle T+2.
- result holds its value until the next DONE. It is never cleared except by reset.
- flush: in any state other than IDLE, the next state is IDLE, busy=0, no done, result unchanged. Flush has priority over start in IDLE.
- start deasserted mid-operation is ignored; the operation completes (the pipeline uses flush to abort).
- start while busy is ignored; there is no queuing.
- Simultaneous done and start for a new instruction: the new op is accepted only in the next IDLE cycle.

Test Plan:
- DIV 100 / 7, start held from T: stall=1 through T+34, done at T+35, result=14, busy=0 at T+36.
- REM -7 / 2: result=0xFFFFFFFF (-1). DIV -7 / 2: result=0xFFFFFFFD (-3).
- DIVU 0xFFFFFFFF / 1: result=0xFFFFFFFF. REMU 0xFFFFFFFF / 0x10: result=0xF.
- DIV 5 / 0: result=0xFFFFFFFF. REM 5 / 0: result=5. Both with done at T+2.
- DIV 0x80000000 / 0xFFFFFFFF: result=0x80000000, done at T+2. REM of the same operands: result=0.
- Abort cases:
  - Flush at T+10: busy=0 at T+11, no done, result keeps its prior value.
  - rst_n low at T+20: all outputs 0 immediately.
  - Either case, then a new DIVU 9/3 completes with result=3.
